mmu_chain_translator: RTL and testbench



---
 rtl/mmu_pkg.sv | 31 +++
 rtl/mmu_page_alloc.sv | 55 +++++
 rtl/mmu_chain_translator.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mmu_chain_translator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types for the page-chain MMU: request opcodes, error codes and FSM states.
package mmu_pkg;

    typedef enum logic [1:0] {
        OP_TRANSLATE = 2'd0,
        OP_CREATE    = 2'd1,
        OP_DESTROY   = 2'd2,
        OP_RSVD      = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_NO_PAGES = 2'd1,
        ERR_NO_PROC  = 2'd2,
        ERR_EXISTS   = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_ALLOC = 3'd2,
        ST_FREE  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] MMU_ERR_OK       = 2'd0;
    localparam logic [1:0] MMU_ERR_NO_PAGES = 2'd1;
    localparam logic [1:0] MMU_ERR_NO_PROC  = 2'd2;
    localparam logic [1:0] MMU_ERR_EXISTS   = 2'd3;

endpackage

// File: rtl/mmu_page_alloc.sv
// Physical page allocator: ownership bit vector, next-fit hint, free counter and
// a one-index-per-cycle wrap-around scan for the first unowned page.
module mmu_page_alloc #(
    parameter int unsigned LP_W = 7
) (
    input  logic            clka,
    input  logic            rst,
    input  logic            scan_start,
    input  logic            scan_step,
    input  logic            free_en,
    input  logic [LP_W-1:0] free_idx,
    output logic            found_c,
    output logic [LP_W-1:0] scan_idx,
    output logic [LP_W:0]   free_pages
);

    localparam int unsigned PHYS_PAGES = 2 ** LP_W;
    localparam int unsigned FREE_W     = LP_W + 1;

    logic [PHYS_PAGES-1:0] page_valid;
    logic [LP_W-1:0]       hint;

    // The page under the scan pointer is claimable this cycle
    assign found_c = scan_step && !page_valid[scan_idx];

    // Scan pointer, ownership bits, hint and free count
    always_ff @(posedge clka) begin
        if (rst) begin
            page_valid <= '0;
            hint       <= '0;
            scan_idx   <= '0;
            free_pages <= FREE_W'(PHYS_PAGES);
        end else begin
            if (scan_start) begin
                scan_idx <= hint;
            end else if (scan_step) begin
                if (found_c) begin
                    page_valid[scan_idx] <= 1'b1;
                    hint                 <= scan_idx + 1'b1;
                    free_pages           <= free_pages - 1'b1;
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end
            if (free_en) begin
                page_valid[free_idx] <= 1'b0;
                free_pages           <= free_pages + 1'b1;
                if (free_idx < hint) begin
                    hint <= free_idx;
                end
            end
        end
    end

endmodule

// File: rtl/mmu_chain_translator.sv
// Page-chain MMU for PROC_N processes: logical->physical translation by chain walk,
// first-touch page allocation, process create/destroy.
// Optional macro MMU_LAST_HIT_EN adds a per-process last-translation register that
// answers repeated hits one cycle after accept without walking.
module mmu_chain_translator
    import mmu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PAGE_W = 3,
    parameter int unsigned PID_W  = 3
) (
    input  logic                   clka,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [PID_W-1:0]       req_pid,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   resp_valid,
    output logic [ADDR_W-1:0]      resp_addr,
    output logic [1:0]             resp_err,
    output logic [ADDR_W-PAGE_W:0] free_pages
);

    localparam int unsigned LP_W       = ADDR_W - PAGE_W;
    localparam int unsigned PHYS_PAGES = 2 ** LP_W;
    localparam int unsigned PROC_N     = 2 ** PID_W;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [PID_W-1:0]   pid_q, pid_d;
    logic [LP_W-1:0]    lpage_q, lpage_d;
    logic [PAGE_W-1:0]  off_q, off_d;
    logic [LP_W-1:0]    cur_q, cur_d;
    logic               resp_valid_d;
    logic [ADDR_W-1:0]  resp_addr_d;
    logic [1:0]         resp_err_d;

    logic [PROC_N-1:0]  proc_valid;
    logic [LP_W-1:0]    proc_start [PROC_N];
    logic [LP_W-1:0]    page_owner [PHYS_PAGES];
    logic [LP_W-1:0]    page_next  [PHYS_PAGES];

    logic               scan_start;
    logic               scan_step;
    logic               free_en;
    logic               found_c;
    logic [LP_W-1:0]    scan_idx;
    logic               alloc_done;
    logic               proc_destroy;
    logic               cur_tail_c;

    assign cur_tail_c = (page_next[cur_q] == cur_q);
    assign scan_step  = (state_q == ST_ALLOC);

    mmu_page_alloc #(
        .LP_W(LP_W)
    ) u_alloc (
        .clka      (clka),
        .rst       (rst),
        .scan_start(scan_start),
        .scan_step (scan_step),
        .free_en   (free_en),
        .free_idx  (cur_q),
        .found_c   (found_c),
        .scan_idx  (scan_idx),
        .free_pages(free_pages)
    );

`ifdef MMU_LAST_HIT_EN
    logic [PROC_N-1:0] lh_valid;
    logic [LP_W-1:0]   lh_lpage [PROC_N];
    logic [LP_W-1:0]   lh_ppage [PROC_N];
    logic              lh_hit_c;
    logic              lh_update_c;

    assign lh_hit_c    = lh_valid[req_pid] && (lh_lpage[req_pid] == req_addr[ADDR_W-1:PAGE_W]);
    assign lh_update_c = resp_valid_d && (op_q == OP_TRANSLATE) && (resp_err_d == MMU_ERR_OK)
                         && ((state_q == ST_WALK) || (state_q == ST_ALLOC));

    // Last-hit valid bits: set on a walked/allocated translation, dropped on destroy
    always_ff @(posedge clka) begin
        if (rst) begin
            lh_valid <= '0;
        end else if (state_q == ST_FREE) begin
            lh_valid[pid_q] <= 1'b0;
        end else if (lh_update_c) begin
            lh_valid[pid_q] <= 1'b1;
        end
    end

    // Last-hit payload, meaningful only while the valid bit is set
    always_ff @(posedge clka) begin
        if (lh_update_c) begin
            lh_lpage[pid_q] <= lpage_q;
            lh_ppage[pid_q] <= resp_addr_d[ADDR_W-1:PAGE_W];
        end
    end
`endif

    // FSM state and registered request/response fields
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_err   <= MMU_ERR_OK;
            op_q       <= OP_TRANSLATE;
            pid_q      <= '0;
            lpage_q    <= '0;
            off_q      <= '0;
            cur_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == ST_IDLE);
            resp_valid <= resp_valid_d;
            resp_addr  <= resp_addr_d;
            resp_err   <= resp_err_d;
            op_q       <= op_d;
            pid_q      <= pid_d;
            lpage_q    <= lpage_d;
            off_q      <= off_d;
            cur_q      <= cur_d;
        end
    end

    // Next-state, response and table-update strobes
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pid_d        = pid_q;
        lpage_d      = lpage_q;
        off_d        = off_q;
        cur_d        = cur_q;
        resp_valid_d = 1'b0;
        resp_addr_d  = '0;
        resp_err_d   = MMU_ERR_OK;
        scan_start   = 1'b0;
        free_en      = 1'b0;
        alloc_done   = 1'b0;
        proc_destroy = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d         = op_t'(req_op);
                    pid_d        = req_pid;
                    lpage_d      = req_addr[ADDR_W-1:PAGE_W];
                    off_d        = req_addr[PAGE_W-1:0];
                    // Immediate response unless a multi-cycle operation starts below
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    case (op_t'(req_op))
                        OP_TRANSLATE: begin
                            if (!proc_valid[req_pid]) begin
                                resp_err_d = MMU_ERR_NO_PROC;
`ifdef MMU_LAST_HIT_EN
                            end else if (lh_hit_c) begin
                                resp_addr_d = {lh_ppage[req_pid], req_addr[PAGE_W-1:0]};
`endif
                            end else begin
                                state_d      = ST_WALK;
                                resp_valid_d = 1'b0;
                                cur_d        = proc_start[req_pid];
                            end
                        end
                        OP_CREATE: begin
                            lpage_d = '0;
                            off_d   = '0;
                            if (proc_valid[req_pid]) begin
                                resp_err_d = MMU_ERR_EXISTS;
                            end else if (free_pages == '0) begin
                                resp_err_d = MMU_ERR_NO_PAGES;
                            end else begin
                                state_d      = ST_ALLOC;
                                resp_valid_d = 1'b0;
                                scan_start   = 1'b1;
                            end
                        end
                        OP_DESTROY: begin
                            if (!proc_valid[req_pid]) begin
                                resp_err_d = MMU_ERR_NO_PROC;
                            end else begin
                                state_d      = ST_FREE;
                                resp_valid_d = 1'b0;
                                cur_d        = proc_start[req_pid];
                            end
                        end
                        default: begin
                            resp_err_d = MMU_ERR_NO_PROC;
                        end
                    endcase
                end
            end
            ST_WALK: begin
                if (page_owner[cur_q] == lpage_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_addr_d  = {cur_q, off_q};
                end else if (cur_tail_c) begin
                    // Miss: cur_q stays on the tail so the new page can be linked after it
                    if (free_pages == '0) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = MMU_ERR_NO_PAGES;
                    end else begin
                        state_d    = ST_ALLOC;
                        scan_start = 1'b1;
                    end
                end else begin
                    cur_d = page_next[cur_q];
                end
            end
            ST_ALLOC: begin
                if (found_c) begin
                    alloc_done   = 1'b1;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_addr_d  = {scan_idx, off_q};
                end
            end
            ST_FREE: begin
                free_en = 1'b1;
                if (cur_tail_c) begin
                    proc_destroy = 1'b1;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    cur_d = page_next[cur_q];
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Process valid bits
    always_ff @(posedge clka) begin
        if (rst) begin
            proc_valid <= '0;
        end else if (alloc_done && (op_q == OP_CREATE)) begin
            proc_valid[pid_q] <= 1'b1;
        end else if (proc_destroy) begin
            proc_valid[pid_q] <= 1'b0;
        end
    end

    // Chain tables: new page becomes a self-linked tail, appended or made the start page
    always_ff @(posedge clka) begin
        if (alloc_done) begin
            page_owner[scan_idx] <= lpage_q;
            page_next[scan_idx]  <= scan_idx;
            if (op_q == OP_TRANSLATE) begin
                page_next[cur_q] <= scan_idx;
            end else begin
                proc_start[pid_q] <= scan_idx;
            end
        end
    end

endmodule

// File: tb/tb_mmu_chain_translator.sv
// Directed self-checking bench for mmu_chain_translator (ADDR_W=10, PAGE_W=3, PID_W=3).
module tb_mmu_chain_translator;

    localparam logic [1:0] OP_T = 2'd0;
    localparam logic [1:0] OP_C = 2'd1;
    localparam logic [1:0] OP_D = 2'd2;
    localparam logic [1:0] OP_R = 2'd3;

`ifdef MMU_LAST_HIT_EN
    localparam int RPT_LAT = 1;
`else
    localparam int RPT_LAT = 3;
`endif

    logic       clka;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_pid;
    logic [9:0] req_addr;
    logic       resp_valid;
    logic [9:0] resp_addr;
    logic [1:0] resp_err;
    logic [7:0] free_pages;

    int total;
    int bad;

    mmu_chain_translator dut (
        .clka      (clka),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_pid   (req_pid),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_addr (resp_addr),
        .resp_err  (resp_err),
        .free_pages(free_pages)
    );

    always #5 clka = ~clka;

    // Issue one request; return latency (cycles after accept) and the response fields
    task automatic do_req(input logic [1:0] op, input logic [2:0] pid, input logic [9:0] addr,
                          output int lat, output logic [9:0] ra, output logic [1:0] re,
                          output logic [7:0] fp);
        int guard;
        guard = 0;
        lat = 0;
        ra = '0;
        re = '0;
        fp = '0;
        @(negedge clka);
        while (req_ready !== 1'b1 && guard < 200) begin
            @(negedge clka);
            guard++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_pid   = pid;
        req_addr  = addr;
        @(posedge clka);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clka);
            if (resp_valid === 1'b1) begin
                lat = c;
                ra  = resp_addr;
                re  = resp_err;
                fp  = free_pages;
                break;
            end
        end
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: op=%0d pid=%0d addr=%h no resp_valid", op, pid, addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (3) @(posedge clka);
        @(negedge clka);
        rst = 1'b0;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        total++;
        if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b required 0", resp_valid); end
        total++;
        if (resp_addr !== 10'h000 || resp_err !== 2'd0) begin
            bad++; $display("FAIL reset_resp: addr=%h err=%0d required 000/0", resp_addr, resp_err);
        end
        total++;
        if (free_pages !== 8'd128) begin bad++; $display("FAIL reset_free: got %0d required 128", free_pages); end
    endtask

    task automatic test_create_translate();
        int lat; logic [9:0] ra; logic [1:0] re; logic [7:0] fp;
        do_req(OP_C, 3'd0, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h000 || fp !== 8'd127 || lat != 2) begin
            bad++; $display("FAIL create_pid0: err=%0d addr=%h free=%0d lat=%0d required 0/000/127/2", re, ra, fp, lat);
        end
        do_req(OP_T, 3'd0, 10'h005, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h005 || lat != 2) begin
            bad++; $display("FAIL tr_005: err=%0d addr=%h lat=%0d required 0/005/2", re, ra, lat);
        end
        do_req(OP_T, 3'd0, 10'h00B, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h00B || fp !== 8'd126 || lat != 3) begin
            bad++; $display("FAIL tr_00B_alloc: err=%0d addr=%h free=%0d lat=%0d required 0/00B/126/3", re, ra, fp, lat);
        end
        do_req(OP_T, 3'd0, 10'h00B, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h00B || fp !== 8'd126 || lat != RPT_LAT) begin
            bad++; $display("FAIL tr_00B_repeat: err=%0d addr=%h free=%0d lat=%0d required 0/00B/126/%0d", re, ra, fp, lat, RPT_LAT);
        end
    endtask

    task automatic test_multi_proc();
        int lat; logic [9:0] ra; logic [1:0] re; logic [7:0] fp;
        do_req(OP_C, 3'd1, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h010 || fp !== 8'd125) begin
            bad++; $display("FAIL create_pid1: err=%0d addr=%h free=%0d required 0/010/125", re, ra, fp);
        end
        do_req(OP_T, 3'd1, 10'h003, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h013) begin
            bad++; $display("FAIL tr_pid1_003: err=%0d addr=%h required 0/013", re, ra);
        end
        do_req(OP_D, 3'd0, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h000 || fp !== 8'd127 || lat != 3) begin
            bad++; $display("FAIL destroy_pid0: err=%0d addr=%h free=%0d lat=%0d required 0/000/127/3", re, ra, fp, lat);
        end
        do_req(OP_T, 3'd0, 10'h00B, lat, ra, re, fp);
        total++;
        if (re !== 2'd2 || ra !== 10'h000 || lat != 1) begin
            bad++; $display("FAIL tr_destroyed: err=%0d addr=%h lat=%0d required 2/000/1", re, ra, lat);
        end
        do_req(OP_C, 3'd2, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h000 || fp !== 8'd126) begin
            bad++; $display("FAIL create_pid2: err=%0d addr=%h free=%0d required 0/000/126", re, ra, fp);
        end
    endtask

    task automatic test_exhaust();
        int lat; logic [9:0] ra; logic [1:0] re; logic [7:0] fp;
        logic [9:0] exp_a; logic [6:0] pp; logic [2:0] off;
        for (int k = 1; k <= 126; k++) begin
            off   = 3'(k % 8);
            pp    = (k == 1) ? 7'd1 : 7'(k + 1);
            exp_a = {pp, off};
            do_req(OP_T, 3'd2, {7'(k), off}, lat, ra, re, fp);
            total++;
            if (re !== 2'd0 || ra !== exp_a || fp !== 8'(126 - k)) begin
                bad++; $display("FAIL fill_lpage%0d: err=%0d addr=%h free=%0d required 0/%h/%0d", k, re, ra, fp, exp_a, 126 - k);
            end
        end
        do_req(OP_T, 3'd2, 10'h3F8, lat, ra, re, fp);
        total++;
        if (re !== 2'd1 || ra !== 10'h000 || fp !== 8'd0 || lat != 128) begin
            bad++; $display("FAIL oop: err=%0d addr=%h free=%0d lat=%0d required 1/000/0/128", re, ra, fp, lat);
        end
        do_req(OP_T, 3'd2, 10'h02A, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h032 || fp !== 8'd0) begin
            bad++; $display("FAIL after_oop: err=%0d addr=%h free=%0d required 0/032/0", re, ra, fp);
        end
    endtask

    task automatic test_errors();
        int lat; logic [9:0] ra; logic [1:0] re; logic [7:0] fp;
        do_req(OP_T, 3'd5, 10'h010, lat, ra, re, fp);
        total++;
        if (re !== 2'd2 || lat != 1) begin bad++; $display("FAIL tr_pid5: err=%0d lat=%0d required 2/1", re, lat); end
        for (int i = 0; i < 2; i++) begin
            do_req(OP_C, 3'd1, 10'h000, lat, ra, re, fp);
            total++;
            if (re !== 2'd3 || ra !== 10'h000 || lat != 1) begin
                bad++; $display("FAIL create_exists%0d: err=%0d addr=%h lat=%0d required 3/000/1", i, re, ra, lat);
            end
        end
        do_req(OP_R, 3'd1, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd2 || lat != 1) begin bad++; $display("FAIL op3: err=%0d lat=%0d required 2/1", re, lat); end
        do_req(OP_D, 3'd6, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd2 || lat != 1) begin bad++; $display("FAIL destroy_pid6: err=%0d lat=%0d required 2/1", re, lat); end
        do_req(OP_C, 3'd3, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd1 || fp !== 8'd0 || lat != 1) begin
            bad++; $display("FAIL create_full: err=%0d free=%0d lat=%0d required 1/0/1", re, fp, lat);
        end
    endtask

    task automatic test_destroy_long();
        int lat; logic [9:0] ra; logic [1:0] re; logic [7:0] fp;
        do_req(OP_D, 3'd2, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || fp !== 8'd127 || lat != 128) begin
            bad++; $display("FAIL destroy_pid2: err=%0d free=%0d lat=%0d required 0/127/128", re, fp, lat);
        end
        do_req(OP_T, 3'd1, 10'h007, lat, ra, re, fp);
        total++;
        if (re !== 2'd0 || ra !== 10'h017) begin
            bad++; $display("FAIL tr_pid1_survives: err=%0d addr=%h required 0/017", re, ra);
        end
    endtask

    task automatic test_reset_mid_alloc();
        int lat; logic [9:0] ra; logic [1:0] re; logic [7:0] fp; int seen;
        @(negedge clka);
        req_valid = 1'b1;
        req_op    = OP_C;
        req_pid   = 3'd3;
        req_addr  = 10'h000;
        @(posedge clka);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clka);
        #1 rst = 1'b0;
        @(negedge clka);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || free_pages !== 8'd128) begin
            bad++; $display("FAIL mid_reset: rv=%b ready=%b free=%0d required 0/1/128", resp_valid, req_ready, free_pages);
        end
        seen = 0;
        repeat (5) begin
            @(negedge clka);
            if (resp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_reset_resp: resp pulses=%0d required 0", seen); end
        do_req(OP_T, 3'd3, 10'h000, lat, ra, re, fp);
        total++;
        if (re !== 2'd2 || fp !== 8'd128) begin
            bad++; $display("FAIL mid_reset_proc: err=%0d free=%0d required 2/128", re, fp);
        end
    endtask

    initial begin
        clka      = 1'b0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_pid   = 3'd0;
        req_addr  = 10'h000;
        total     = 0;
        bad       = 0;
        test_reset();
        test_create_translate();
        test_multi_proc();
        test_exhaust();
        test_errors();
        test_destroy_long();
        test_reset_mid_alloc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
